// File: rtl/ky32_mul_iter.sv
// ky32_mul_iter: iterative unsigned 32x32->64 shift-add multiplier.
// One add per BUSY cycle through a 32-bit carry-lookahead adder (cla32).
// Optional macro KY32_MUL_EARLY_EXIT_EN: finish as soon as the remaining
// multiplier bits are all zero, aligning the partial product with a shift.

// 32-bit two-level carry-lookahead adder (8 groups of 4 bits).
module cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c,
    output logic [31:0] sum,
    output logic        g_o,
    output logic        p_o
);
    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [31:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Group generate/propagate, group carries, then per-bit lookahead carries.
    always_comb begin
        logic [7:0] gg;
        logic [7:0] gp;
        logic [8:0] cg;
        w_c = '0;
        gg  = '0;
        gp  = '0;
        cg  = '0;
        cg[0] = c;
        for (int j = 0; j < 8; j++) begin
            gg[j] = w_g[4*j+3] | (w_p[4*j+3] & w_g[4*j+2])
                  | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
                  | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
            gp[j] = &w_p[4*j +: 4];
            cg[j+1] = gg[j] | (gp[j] & cg[j]);
            w_c[4*j]   = cg[j];
            w_c[4*j+1] = w_g[4*j] | (w_p[4*j] & cg[j]);
            w_c[4*j+2] = w_g[4*j+1] | (w_p[4*j+1] & w_g[4*j])
                       | (w_p[4*j+1] & w_p[4*j] & cg[j]);
            w_c[4*j+3] = w_g[4*j+2] | (w_p[4*j+2] & w_g[4*j+1])
                       | (w_p[4*j+2] & w_p[4*j+1] & w_g[4*j])
                       | (w_p[4*j+2] & w_p[4*j+1] & w_p[4*j] & cg[j]);
        end
    end

    // Block-level generate/propagate so the caller can form carry-out.
    always_comb begin
        g_o = 1'b0;
        for (int j = 0; j < 32; j++)
            g_o = w_g[j] | (w_p[j] & g_o);
    end

    assign p_o = &w_p;
    assign sum = w_p ^ w_c;
endmodule

module ky32_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);
    if (WIDTH != 32) begin : g_width_chk
        $error("ky32_mul_iter: only WIDTH=32 is supported");
    end

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_m;
    logic [31:0] r_acc;
    logic [31:0] r_q;
    logic [4:0]  r_k;
    logic [63:0] r_p;

    logic [31:0] w_addb;
    logic [31:0] w_sum;
    logic        w_g;
    logic        w_pp;
    logic        w_cout;
    logic [31:0] w_acc_n;
    logic [31:0] w_q_n;
    logic        w_last;
    logic        w_skip;
`ifdef KY32_MUL_EARLY_EXIT_EN
    logic [5:0]  w_shamt;
    assign w_skip  = ((r_q & (32'hFFFF_FFFF >> r_k)) == 32'h0);
    assign w_shamt = 6'd32 - {1'b0, r_k};
`else
    assign w_skip  = 1'b0;
`endif

    assign w_addb = r_q[0] ? r_m : 32'h0;

    cla32 u_cla (
        .a   (r_acc),
        .b   (w_addb),
        .c   (1'b0),
        .sum (w_sum),
        .g_o (w_g),
        .p_o (w_pp)
    );

    // Carry-in is tied low, so the p_o term is kept only for clarity of intent.
    assign w_cout  = w_g | (w_pp & 1'b0);
    assign w_acc_n = {w_cout, w_sum[31:1]};
    assign w_q_n   = {w_sum[0], r_q[31:1]};
    assign w_last  = (r_k == 5'd31) || w_skip;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_BUSY;
            S_BUSY:  if (w_last)   w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state.
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        busy      = (r_state != S_IDLE);
    end

    // Shift-add datapath: {ACC,Q} shifts right 65 bits wide each BUSY cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m   <= '0;
            r_acc <= '0;
            r_q   <= '0;
            r_k   <= '0;
            r_p   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_m   <= a;
                    r_acc <= '0;
                    r_q   <= b;
                    r_k   <= '0;
                end
                S_BUSY: begin
`ifdef KY32_MUL_EARLY_EXIT_EN
                    if (w_skip) begin
                        r_p <= {r_acc, r_q} >> w_shamt;
                    end else
`endif
                    begin
                        r_acc <= w_acc_n;
                        r_q   <= w_q_n;
                        r_k   <= r_k + 5'd1;
                        if (r_k == 5'd31) r_p <= {w_acc_n, w_q_n};
                    end
                end
                default: ;
            endcase
        end
    end

    assign p = r_p;
endmodule

// File: tb/tb_ky32_mul_iter.sv
// Directed table plus corner sequences and a short random run for ky32_mul_iter.
module tb_ky32_mul_iter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] p;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          stall;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    ky32_mul_iter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .p(p), .busy(busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic int exp_cycles(input logic [31:0] mb);
`ifdef KY32_MUL_EARLY_EXIT_EN
        int h;
        if (mb == 32'h0) return 1;
        h = 0;
        for (int i = 0; i < 32; i++) if (mb[i]) h = i;
        return (h + 2 > 32) ? 32 : h + 2;
`else
        return 32;
`endif
    endfunction

    // Accept operands, count BUSY cycles, optionally stall, then complete handshake.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic [63:0] exp,
                         input int stall, input string nm);
        int n;
        logic ok;
        logic [63:0] held;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (!in_ready) begin chk({nm, " accept-timeout"}, 0, 1); return; end
        a = ta; b = tb; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        n = 0; ok = 1'b1;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            if (in_ready || !busy) ok = 1'b0;
            n++;
            @(negedge clk);
        end
        chk({nm, " latency"}, 64'(n), 64'(exp_cycles(tb)));
        chk({nm, " in_ready-low-busy"}, {63'b0, ok}, 64'd1);
        chk({nm, " product"}, p, exp);
        held = p; ok = 1'b1;
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1; a = ~ta; b = ~tb;
            @(negedge clk);
            if (p !== held || !out_valid || in_ready) ok = 1'b0;
        end
        in_valid = 1'b0;
        if (stall > 0) chk({nm, " stall-hold"}, {63'b0, ok}, 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        chk({nm, " post out_valid"}, {63'b0, out_valid}, 64'd0);
        chk({nm, " post in_ready"}, {63'b0, in_ready}, 64'd1);
    endtask

    initial begin
        vecs[0]  = '{32'd3,          32'd5,          64'h0000_0000_0000_000F, 0};
        vecs[1]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 0};
        vecs[2]  = '{32'h1234_5678,  32'h9ABC_DEF0,  64'h0B00_EA4E_242D_2080, 10};
        vecs[3]  = '{32'h1234_5678,  32'h0,          64'h0,                   0};
        vecs[4]  = '{32'd9,          32'h0000_0004,  64'd36,                  0};
        vecs[5]  = '{32'd2,          32'h8000_0001,  64'h0000_0001_0000_0002, 2};
        vecs[6]  = '{32'd1,          32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFFF, 0};
        vecs[7]  = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000, 0};
        vecs[8]  = '{32'hFFFF_FFFF,  32'd2,          64'h0000_0001_FFFF_FFFE, 1};
        vecs[9]  = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000, 0};
        vecs[10] = '{32'hDEAD_BEEF,  32'd1,          64'h0000_0000_DEAD_BEEF, 0};
        vecs[11] = '{32'h0,          32'hFFFF_FFFF,  64'h0,                   3};

        // Reset state while reset is held.
        #12;
        chk("reset in_ready", {63'b0, in_ready}, 64'd1);
        chk("reset out_valid", {63'b0, out_valid}, 64'd0);
        chk("reset busy", {63'b0, busy}, 64'd0);
        chk("reset p", p, 64'd0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 12; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].stall, $sformatf("vec%0d", i));

        // Abort mid-BUSY after 10 iterations; nothing partial may appear.
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h9ABC_DEF0; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("abort pre busy", {63'b0, busy}, 64'd1);
        rst = 1'b1; #1;
        chk("abort out_valid", {63'b0, out_valid}, 64'd0);
        chk("abort in_ready", {63'b0, in_ready}, 64'd1);
        chk("abort p", p, 64'd0);
        chk("abort busy", {63'b0, busy}, 64'd0);
        @(negedge clk); rst = 1'b0;
        do_op(32'd7, 32'd6, 64'd42, 0, "post-abort");

        // Random pairs with random back-pressure.
        for (int r = 0; r < 300; r++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (r % 7 == 0) ? ($urandom >> $urandom_range(0, 31)) : $urandom;
            do_op(ra, rb, {32'b0, ra} * {32'b0, rb}, $urandom_range(0, 3), $sformatf("rnd%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
